// File: rtl/tetris_board_ram.sv
// Tetris board-state memory: 21 x 42 cells of 3-bit colour.
// Controller read/write port (1-cycle read latency), renderer read-only port
// (2-cycle pipelined latency), and a clear-sweep engine that whitens the board
// after reset or on clear_req.
// Optional feature: define TETRIS_BOARD_BOUNDS_EN to treat x>20 / y>41 as
// out of range (writes dropped, reads return wall code 4'd8).
module tetris_board_ram (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sram_we,
    input  logic       sram_re,
    input  logic [4:0] curr_x,
    input  logic [5:0] curr_y,
    input  logic [2:0] color_w,
    output logic [3:0] sram_color,
    input  logic       draw_re,
    input  logic [4:0] draw_cell_x,
    input  logic [5:0] draw_cell_y,
    output logic [3:0] draw_color,
    output logic       draw_valid,
    input  logic       clear_req,
    output logic       busy
);
    localparam int unsigned Cells    = 882;
    localparam logic [9:0]  LastIdx  = 10'd881;
    localparam logic [9:0]  NumCells = 10'd882;
    localparam logic [2:0]  White    = 3'd7;

    typedef enum logic {StClear, StIdle} state_t;
    typedef enum logic [1:0] {KindMem, KindWhite, KindWall} kind_t;

    state_t     state_q, state_d;
    logic [9:0] clr_idx_q, clr_idx_d;

    logic [2:0] mem [Cells];

    // y*21 + x as shifts and adds, truncated to 10 bits
    function automatic logic [9:0] cell_idx(input logic [4:0] x, input logic [5:0] y);
        logic [9:0] yy;
        yy = {4'd0, y};
        return (yy << 4) + (yy << 2) + yy + {5'd0, x};
    endfunction

    logic [9:0] ctl_idx, drw_idx;
    logic       ctl_in_range, drw_in_range;
    logic       ctl_cell_ok, drw_cell_ok;

    assign ctl_idx     = cell_idx(curr_x, curr_y);
    assign drw_idx     = cell_idx(draw_cell_x, draw_cell_y);
    assign ctl_cell_ok = (ctl_idx < NumCells);
    assign drw_cell_ok = (drw_idx < NumCells);

`ifdef TETRIS_BOARD_BOUNDS_EN
    assign ctl_in_range = (curr_x <= 5'd20) && (curr_y <= 6'd41);
    assign drw_in_range = (draw_cell_x <= 5'd20) && (draw_cell_y <= 6'd41);
`else
    assign ctl_in_range = 1'b1;
    assign drw_in_range = 1'b1;
`endif

    assign busy = (state_q == StClear);

    // FSM state and sweep counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_idx_q <= 10'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: sweep to the last cell, then idle until clear_req
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StClear: begin
                if (clr_idx_q == LastIdx) begin
                    state_d   = StIdle;
                    clr_idx_d = 10'd0;
                end else begin
                    clr_idx_d = clr_idx_q + 10'd1;
                end
            end
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    clr_idx_d = 10'd0;
                end
            end
            default: ;
        endcase
    end

    // Single write port: the sweep owns it while clearing
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_idx_q] <= White;
        end else if (sram_we && ctl_in_range && ctl_cell_ok) begin
            mem[ctl_idx] <= color_w;
        end
    end

    // Controller read data before registering; old cell value gives read-before-write
    logic [3:0] ctl_rdata;
    always_comb begin
        ctl_rdata = 4'd7;
        if (state_q == StIdle) begin
            if (!ctl_in_range) begin
                ctl_rdata = 4'd8;
            end else if (ctl_cell_ok) begin
                ctl_rdata = {1'b0, mem[ctl_idx]};
            end
        end
    end

    // Controller read register; holds when sram_re is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_color <= 4'd7;
        end else if (sram_re) begin
            sram_color <= ctl_rdata;
        end
    end

    // Renderer stage 1: classify the request while the FSM state is current
    kind_t      drw_kind, d1_kind_q;
    logic       d1_valid_q;
    logic [9:0] d1_idx_q;

    always_comb begin
        drw_kind = KindWhite;
        if (state_q == StIdle) begin
            if (!drw_in_range) begin
                drw_kind = KindWall;
            end else if (drw_cell_ok) begin
                drw_kind = KindMem;
            end
        end
    end

    // Renderer request pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_valid_q <= 1'b0;
            d1_idx_q   <= 10'd0;
            d1_kind_q  <= KindWhite;
        end else begin
            d1_valid_q <= draw_re;
            if (draw_re) begin
                d1_idx_q  <= drw_idx;
                d1_kind_q <= drw_kind;
            end
        end
    end

    // Renderer stage 2: fetch the cell
    logic [3:0] d2_color;
    always_comb begin
        d2_color = 4'd7;
        case (d1_kind_q)
            KindMem:  d2_color = {1'b0, mem[d1_idx_q]};
            KindWall: d2_color = 4'd8;
            default:  d2_color = 4'd7;
        endcase
    end

    // Renderer output register; colour holds when no request arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_valid <= 1'b0;
            draw_color <= 4'd0;
        end else begin
            draw_valid <= d1_valid_q;
            if (d1_valid_q) begin
                draw_color <= d2_color;
            end
        end
    end

endmodule

// File: tb/tb_tetris_board_ram.sv
// Directed self-checking bench for tetris_board_ram.
module tb_tetris_board_ram;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sram_we = 1'b0;
    logic       sram_re = 1'b0;
    logic [4:0] curr_x = '0;
    logic [5:0] curr_y = '0;
    logic [2:0] color_w = '0;
    logic [3:0] sram_color;
    logic       draw_re = 1'b0;
    logic [4:0] draw_cell_x = '0;
    logic [5:0] draw_cell_y = '0;
    logic [3:0] draw_color;
    logic       draw_valid;
    logic       clear_req = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tetris_board_ram dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sram_we     (sram_we),
        .sram_re     (sram_re),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .color_w     (color_w),
        .sram_color  (sram_color),
        .draw_re     (draw_re),
        .draw_cell_x (draw_cell_x),
        .draw_cell_y (draw_cell_y),
        .draw_color  (draw_color),
        .draw_valid  (draw_valid),
        .clear_req   (clear_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic ctl_write(input logic [4:0] x, input logic [5:0] y, input logic [2:0] c);
        @(posedge clk); #1;
        sram_we = 1'b1; curr_x = x; curr_y = y; color_w = c;
        @(posedge clk); #1;
        sram_we = 1'b0;
    endtask

    task automatic ctl_read(input logic [4:0] x, input logic [5:0] y, output logic [3:0] v);
        @(posedge clk); #1;
        sram_re = 1'b1; curr_x = x; curr_y = y;
        @(posedge clk); #1;
        sram_re = 1'b0;
        @(negedge clk);
        v = sram_color;
    endtask

    task automatic draw_read(input logic [4:0] x, input logic [5:0] y,
                             output logic [3:0] c, output logic v);
        @(posedge clk); #1;
        draw_re = 1'b1; draw_cell_x = x; draw_cell_y = y;
        @(posedge clk); #1;
        draw_re = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c = draw_color;
        v = draw_valid;
    endtask

    // Counts negedge samples with busy high, starting at the next negedge
    task automatic count_busy(output int n);
        int guard;
        n = 0;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 2000) begin
            n++;
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [3:0] v;
        int n;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %0d expected 1", busy);
        end
        checks++;
        if (sram_color !== 4'd7) begin
            errors++; $display("FAIL reset_sram_color: got %0d expected 7", sram_color);
        end
        checks++;
        if (draw_color !== 4'd0) begin
            errors++; $display("FAIL reset_draw_color: got %0d expected 0", draw_color);
        end
        checks++;
        if (draw_valid !== 1'b0) begin
            errors++; $display("FAIL reset_draw_valid: got %0d expected 0", draw_valid);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 882) begin
            errors++; $display("FAIL reset_sweep_len: got %0d expected 882", n);
        end
        ctl_read(5'd0, 6'd0, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL init_0_0: got %0d expected 7", v);
        end
        ctl_read(5'd20, 6'd41, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL init_20_41: got %0d expected 7", v);
        end
        ctl_read(5'd10, 6'd20, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL init_10_20: got %0d expected 7", v);
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        sram_we = 1'b1; curr_x = 5'd3; curr_y = 6'd5; color_w = 3'd2;
        @(posedge clk); #1;
        sram_we = 1'b0; sram_re = 1'b1;
        draw_re = 1'b1; draw_cell_x = 5'd3; draw_cell_y = 6'd5;
        @(posedge clk); #1;
        sram_re = 1'b0; draw_re = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_color !== 4'd2) begin
            errors++; $display("FAIL wr_rd_ctl: got %0d expected 2", sram_color);
        end
        checks++;
        if (draw_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_draw_early: got valid %0d expected 0", draw_valid);
        end
        @(negedge clk);
        checks++;
        if (draw_color !== 4'd2 || draw_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_draw: got %0d/%0d expected 2/1", draw_color, draw_valid);
        end
        @(negedge clk);
        checks++;
        if (draw_color !== 4'd2 || draw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_draw_hold: got %0d/%0d expected 2/0", draw_color, draw_valid);
        end
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        sram_we = 1'b1; sram_re = 1'b1; curr_x = 5'd7; curr_y = 6'd9; color_w = 3'd4;
        @(posedge clk); #1;
        sram_we = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_color !== 4'd7) begin
            errors++; $display("FAIL rbw_old: got %0d expected 7", sram_color);
        end
        @(posedge clk); #1;
        sram_re = 1'b0; curr_x = 5'd0; curr_y = 6'd0;
        @(negedge clk);
        checks++;
        if (sram_color !== 4'd4) begin
            errors++; $display("FAIL rbw_new: got %0d expected 4", sram_color);
        end
        @(negedge clk);
        checks++;
        if (sram_color !== 4'd4) begin
            errors++; $display("FAIL ctl_hold: got %0d expected 4", sram_color);
        end
    endtask

    task automatic test_back_to_back();
        ctl_write(5'd0, 6'd0, 3'd1);
        ctl_write(5'd1, 6'd0, 3'd2);
        ctl_write(5'd2, 6'd0, 3'd3);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            draw_re = (k < 3);
            draw_cell_x = 5'(k);
            draw_cell_y = 6'd0;
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                checks++;
                if (draw_color !== 4'(k - 1) || draw_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_%0d: got %0d/%0d expected %0d/1",
                             k - 2, draw_color, draw_valid, k - 1);
                end
            end else if (k == 5) begin
                checks++;
                if (draw_valid !== 1'b0 || draw_color !== 4'd3) begin
                    errors++;
                    $display("FAIL b2b_end: got %0d/%0d expected 3/0", draw_color, draw_valid);
                end
            end
        end
        draw_re = 1'b0;
    endtask

    task automatic test_bounds();
        logic [3:0] v;
        logic [3:0] c;
        logic       dv;
`ifdef TETRIS_BOARD_BOUNDS_EN
        ctl_write(5'd0, 6'd1, 3'd5);
        ctl_write(5'd21, 6'd0, 3'd2);
        ctl_read(5'd0, 6'd1, v);
        checks++;
        if (v !== 4'd5) begin
            errors++; $display("FAIL bounds_no_alias: got %0d expected 5", v);
        end
        ctl_read(5'd21, 6'd0, v);
        checks++;
        if (v !== 4'd8) begin
            errors++; $display("FAIL bounds_x21: got %0d expected 8", v);
        end
        ctl_read(5'd0, 6'd42, v);
        checks++;
        if (v !== 4'd8) begin
            errors++; $display("FAIL bounds_y42: got %0d expected 8", v);
        end
        draw_read(5'd21, 6'd0, c, dv);
        checks++;
        if (c !== 4'd8 || dv !== 1'b1) begin
            errors++; $display("FAIL bounds_draw_x21: got %0d/%0d expected 8/1", c, dv);
        end
`else
        ctl_read(5'd0, 6'd42, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL idx882_read: got %0d expected 7", v);
        end
        ctl_write(5'd0, 6'd42, 3'd3);
        ctl_read(5'd0, 6'd42, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL idx882_write_dropped: got %0d expected 7", v);
        end
        ctl_write(5'd21, 6'd0, 3'd2);
        ctl_read(5'd0, 6'd1, v);
        checks++;
        if (v !== 4'd2) begin
            errors++; $display("FAIL alias_x21: got %0d expected 2", v);
        end
        draw_read(5'd0, 6'd42, c, dv);
        checks++;
        if (c !== 4'd7 || dv !== 1'b1) begin
            errors++; $display("FAIL idx882_draw: got %0d/%0d expected 7/1", c, dv);
        end
`endif
    endtask

    task automatic test_clear();
        logic [3:0] v;
        logic [3:0] c;
        logic       dv;
        int n;
        int guard;
        ctl_write(5'd5, 6'd5, 3'd3);
        ctl_write(5'd20, 6'd41, 3'd6);
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        n = 0;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 2000) begin
            n++;
            guard++;
            case (n)
                200: clear_req = 1'b1;
                201: clear_req = 1'b0;
                300: begin
                    sram_re = 1'b1; curr_x = 5'd20; curr_y = 6'd41;
                    draw_re = 1'b1; draw_cell_x = 5'd20; draw_cell_y = 6'd41;
                end
                301: begin
                    checks++;
                    if (sram_color !== 4'd7) begin
                        errors++; $display("FAIL sweep_ctl_read: got %0d expected 7", sram_color);
                    end
                    sram_re = 1'b0; draw_re = 1'b0;
                end
                302: begin
                    checks++;
                    if (draw_color !== 4'd7 || draw_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL sweep_draw_read: got %0d/%0d expected 7/1",
                                 draw_color, draw_valid);
                    end
                end
                500: begin
                    sram_we = 1'b1; curr_x = 5'd5; curr_y = 6'd5; color_w = 3'd1;
                end
                501: sram_we = 1'b0;
                default: ;
            endcase
            @(negedge clk);
        end
        checks++;
        if (n != 882) begin
            errors++; $display("FAIL clear_sweep_len: got %0d expected 882", n);
        end
        ctl_read(5'd5, 6'd5, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL clear_5_5: got %0d expected 7", v);
        end
        ctl_read(5'd20, 6'd41, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL clear_20_41: got %0d expected 7", v);
        end
        ctl_read(5'd3, 6'd5, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL clear_3_5: got %0d expected 7", v);
        end
        draw_read(5'd0, 6'd0, c, dv);
        checks++;
        if (c !== 4'd7 || dv !== 1'b1) begin
            errors++; $display("FAIL clear_draw_0_0: got %0d/%0d expected 7/1", c, dv);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [3:0] v;
        int n;
        int guard;
        ctl_write(5'd2, 6'd0, 3'd3);
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        n = 0;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 400 && guard < 2000) begin
            n++;
            guard++;
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_reset_busy: got %0d expected 1", busy);
        end
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 882) begin
            errors++; $display("FAIL mid_reset_sweep_len: got %0d expected 882", n);
        end
        ctl_read(5'd2, 6'd0, v);
        checks++;
        if (v !== 4'd7) begin
            errors++; $display("FAIL mid_reset_2_0: got %0d expected 7", v);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_bounds();
        test_clear();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
